// File: rtl/riscm_pkg.sv
// Shared definitions for the ALU writeback stage.
//   - nvz bit positions within the 3-bit status vector {N,V,Z}
//   - branch condition select encodings
//   - default datapath widths
//   - occupancy FSM state type
package riscm_pkg;

  localparam int unsigned NVZ_Z = 0;
  localparam int unsigned NVZ_V = 1;
  localparam int unsigned NVZ_N = 2;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_NE     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_LE     = 3'b100;

  localparam int unsigned DEFAULT_DATA_W    = 16;
  localparam int unsigned DEFAULT_REG_IDX_W = 3;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } wb_state_e;

endpackage

// File: rtl/alu_writeback_stage_if.sv
// Bus bundle between the ALU, the writeback stage, the register file and the controller.
// Modports:
//   slave  - the writeback stage: takes ALU entries, presents head entry, drives status/cond_true
//   master - the environment: drives ALU entries, out_ready and cond_sel
interface alu_writeback_stage_if #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned REG_IDX_W = 3
);

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_result;
  logic [2:0]           in_nvz;
  logic [REG_IDX_W-1:0] in_dest;
  logic                 in_write;
  logic                 in_setflags;

  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [REG_IDX_W-1:0] out_dest;
  logic                 out_write;

  logic [2:0]           status;
  logic [2:0]           cond_sel;
  logic                 cond_true;

  modport slave (
    input  in_valid, in_result, in_nvz, in_dest, in_write, in_setflags,
    input  out_ready, cond_sel,
    output in_ready, out_valid, out_data, out_dest, out_write, status, cond_true
  );

  modport master (
    output in_valid, in_result, in_nvz, in_dest, in_write, in_setflags,
    output out_ready, cond_sel,
    input  in_ready, out_valid, out_data, out_dest, out_write, status, cond_true
  );

endinterface

// File: rtl/cond_eval.sv
// Branch condition evaluator: purely combinational map of ({N,V,Z}, cond_sel) to cond_true.
// Ports:
//   i_nvz       - status vector {N,V,Z}
//   i_cond_sel  - condition select (ALWAYS/EQ/NE/LT/LE, others never true)
//   o_cond_true - selected condition holds
module cond_eval
  import riscm_pkg::*;
(
  input  logic [2:0] i_nvz,
  input  logic [2:0] i_cond_sel,
  output logic       o_cond_true
);

  logic w_z;
  logic w_v;
  logic w_n;

  assign w_z = i_nvz[NVZ_Z];
  assign w_v = i_nvz[NVZ_V];
  assign w_n = i_nvz[NVZ_N];

  always_comb begin
    o_cond_true = 1'b0;
    case (i_cond_sel)
      COND_ALWAYS: o_cond_true = 1'b1;
      COND_EQ:     o_cond_true = w_z;
      COND_NE:     o_cond_true = ~w_z;
      COND_LT:     o_cond_true = w_n ^ w_v;
      COND_LE:     o_cond_true = (w_n ^ w_v) | w_z;
      default:     o_cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: in-order buffer of ALU results between the ALU and the register file.
// Retiring an entry with setflags commits its {N,V,Z} to the status register; the branch
// condition is evaluated from the committed status.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset; discards all buffered entries, clears status
//   bus   - alu_writeback_stage_if.slave (ALU input handshake, register file output
//           handshake, status, cond_sel, cond_true)
// Build option:
//   ALU_WB_FLAG_BYPASS_EN - when defined, a retiring head with setflags feeds its nvz straight
//                           into the condition evaluator in the retire cycle.
module alu_writeback_stage
  import riscm_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned REG_IDX_W = DEFAULT_REG_IDX_W
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_writeback_stage_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage
  logic [DATA_W-1:0]    r_data     [DEPTH];
  logic [2:0]           r_nvz      [DEPTH];
  logic [REG_IDX_W-1:0] r_dest     [DEPTH];
  logic                 r_write    [DEPTH];
  logic                 r_setflags [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [2:0]       r_status;

  wb_state_e r_state;
  wb_state_e w_state_next;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  logic [DATA_W-1:0]    w_head_data;
  logic [2:0]           w_head_nvz;
  logic [REG_IDX_W-1:0] w_head_dest;
  logic                 w_head_write;
  logic                 w_head_setflags;

  logic [2:0] w_cond_nvz;
  logic       w_cond_true;

  assign w_head_data     = r_data[r_rd_ptr];
  assign w_head_nvz      = r_nvz[r_rd_ptr];
  assign w_head_dest     = r_dest[r_rd_ptr];
  assign w_head_write    = r_write[r_rd_ptr];
  assign w_head_setflags = r_setflags[r_rd_ptr];

  // in_ready comes from registered state only, so a full buffer refuses a push even when a
  // pop happens in the same cycle.
  assign w_push = bus.in_valid && w_in_ready;
  assign w_pop  = w_out_valid && bus.out_ready;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  // Occupancy FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Occupancy FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_state_next = (w_count_next == FULL_CNT) ? FULL : PARTIAL;
        end
      end
      PARTIAL: begin
        if (w_push && !w_pop && (w_count_next == FULL_CNT)) begin
          w_state_next = FULL;
        end else if (w_pop && !w_push && (w_count_next == '0)) begin
          w_state_next = EMPTY;
        end
      end
      FULL: begin
        if (w_pop) begin
          w_state_next = (w_count_next == '0) ? EMPTY : PARTIAL;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // Occupancy FSM: outputs
  always_comb begin
    w_in_ready  = 1'b1;
    w_out_valid = 1'b0;
    unique case (r_state)
      EMPTY: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
      end
      PARTIAL: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b1;
      end
      FULL: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b1;
      end
      default: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
      end
    endcase
  end

  // Buffer, pointers, count and committed status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_data[i]     <= '0;
        r_nvz[i]      <= '0;
        r_dest[i]     <= '0;
        r_write[i]    <= 1'b0;
        r_setflags[i] <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_status <= 3'b000;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr]     <= bus.in_result;
        r_nvz[r_wr_ptr]      <= bus.in_nvz;
        r_dest[r_wr_ptr]     <= bus.in_dest;
        r_write[r_wr_ptr]    <= bus.in_write;
        r_setflags[r_wr_ptr] <= bus.in_setflags;
        // DEPTH is a power of two, so the natural overflow is the modulo wrap
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_head_setflags) begin
          r_status <= w_head_nvz;
        end
      end
      r_count <= w_count_next;
    end
  end

  // Head entry toward the register file; forced to zero when empty
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? w_head_data : '0;
  assign bus.out_dest  = w_out_valid ? w_head_dest : '0;
  assign bus.out_write = w_out_valid & w_head_write;
  assign bus.status    = r_status;

`ifdef ALU_WB_FLAG_BYPASS_EN
  // Flags of a head retiring this cycle are seen by the condition immediately
  assign w_cond_nvz = (w_pop && w_head_setflags) ? w_head_nvz : r_status;
`else
  assign w_cond_nvz = r_status;
`endif

  cond_eval u_cond_eval (
    .i_nvz       (w_cond_nvz),
    .i_cond_sel  (bus.cond_sel),
    .o_cond_true (w_cond_true)
  );

  assign bus.cond_true = w_cond_true;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_alu_writeback_stage;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned DEPTH     = 2;
  localparam int unsigned REG_IDX_W = 3;

`ifdef ALU_WB_FLAG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0]    data;
    logic [2:0]           nvz;
    logic [REG_IDX_W-1:0] dest;
    logic                 wr;
    logic                 sf;
  } entry_t;

  logic clk;
  logic reset;

  alu_writeback_stage_if #(.DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W)) u_if ();

  alu_writeback_stage #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .REG_IDX_W (REG_IDX_W)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  entry_t     m_q[$];
  logic [2:0] m_status;

  int n_checks;
  int n_errors;

  // Last observed values, for directed checks
  logic             obs_valid;
  logic             obs_ready;
  logic [DATA_W-1:0] obs_data;
  logic [2:0]       obs_status;
  logic             obs_cond;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ref_cond(input logic [2:0] nvz, input logic [2:0] sel);
    logic n, v, z;
    n = nvz[2];
    v = nvz[1];
    z = nvz[0];
    case (sel)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return n != v;
      3'd4:    return (n != v) || z;
      default: return 1'b0;
    endcase
  endfunction

  // One clock cycle: called at posedge+1, drives inputs, checks outputs mid-cycle against
  // the model, then advances the model across the edge.
  task automatic cycle(input logic iv, input logic [DATA_W-1:0] res, input logic [2:0] nvz,
                       input logic [REG_IDX_W-1:0] dest, input logic wr, input logic sf,
                       input logic ordy, input logic [2:0] csel);
    logic       e_valid, e_ready, push, pop;
    logic [2:0] e_nvz;
    entry_t     ent;
    u_if.in_valid    = iv;
    u_if.in_result   = res;
    u_if.in_nvz      = nvz;
    u_if.in_dest     = dest;
    u_if.in_write    = wr;
    u_if.in_setflags = sf;
    u_if.out_ready   = ordy;
    u_if.cond_sel    = csel;
    #3;
    e_valid = (m_q.size() != 0);
    e_ready = (m_q.size() != DEPTH);
    e_nvz   = m_status;
    if (BYPASS && e_valid && ordy && m_q[0].sf) e_nvz = m_q[0].nvz;
    obs_valid  = u_if.out_valid;
    obs_ready  = u_if.in_ready;
    obs_data   = u_if.out_data;
    obs_status = u_if.status;
    obs_cond   = u_if.cond_true;
    check_eq("out_valid", 32'(u_if.out_valid), 32'(e_valid));
    check_eq("in_ready", 32'(u_if.in_ready), 32'(e_ready));
    check_eq("out_data", 32'(u_if.out_data), e_valid ? 32'(m_q[0].data) : 32'd0);
    check_eq("out_dest", 32'(u_if.out_dest), e_valid ? 32'(m_q[0].dest) : 32'd0);
    check_eq("out_write", 32'(u_if.out_write), e_valid ? 32'(m_q[0].wr) : 32'd0);
    check_eq("status", 32'(u_if.status), 32'(m_status));
    check_eq("cond_true", 32'(u_if.cond_true), 32'(ref_cond(e_nvz, csel)));
    @(posedge clk);
    push = iv && e_ready;
    pop  = e_valid && ordy;
    if (pop) begin
      if (m_q[0].sf) m_status = m_q[0].nvz;
      void'(m_q.pop_front());
    end
    if (push) begin
      ent.data = res;
      ent.nvz  = nvz;
      ent.dest = dest;
      ent.wr   = wr;
      ent.sf   = sf;
      m_q.push_back(ent);
    end
    #1;
  endtask

  task automatic idle(input logic ordy, input logic [2:0] csel);
    cycle(1'b0, '0, 3'b000, '0, 1'b0, 1'b0, ordy, csel);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_status = 3'b000;
    reset = 1'b1;
    u_if.in_valid    = 1'b0;
    u_if.in_result   = '0;
    u_if.in_nvz      = '0;
    u_if.in_dest     = '0;
    u_if.in_write    = 1'b0;
    u_if.in_setflags = 1'b0;
    u_if.out_ready   = 1'b0;
    u_if.cond_sel    = 3'd0;

    // Reset state
    #2;
    check_eq("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(u_if.out_data), 32'd0);
    check_eq("rst_out_write", 32'(u_if.out_write), 32'd0);
    check_eq("rst_status", 32'(u_if.status), 32'd0);
    #10 reset = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(u_if.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single pass: Z flag committed on retire, EQ true afterwards
    cycle(1'b1, 16'h0000, 3'b001, 3'd2, 1'b1, 1'b1, 1'b1, 3'd1);
    check_eq("single_empty_cond", 32'(obs_cond), 32'd0);
    cycle(1'b0, 16'h0000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1);
    check_eq("single_valid", 32'(obs_valid), 32'd1);
    check_eq("single_data", 32'(obs_data), 32'h0000);
    idle(1'b1, 3'd1);
    check_eq("single_status", 32'(obs_status), 32'b001);
    check_eq("single_eq", 32'(obs_cond), 32'd1);

    // Backpressure and ordering
    cycle(1'b1, 16'h1234, 3'b000, 3'd1, 1'b1, 1'b0, 1'b0, 3'd0);
    cycle(1'b1, 16'h5678, 3'b000, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0);
    cycle(1'b1, 16'h9abc, 3'b000, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0);
    check_eq("bp_full_ready", 32'(obs_ready), 32'd0);
    idle(1'b1, 3'd0);
    check_eq("bp_first", 32'(obs_data), 32'h1234);
    idle(1'b1, 3'd0);
    check_eq("bp_second", 32'(obs_data), 32'h5678);
    idle(1'b1, 3'd0);
    check_eq("bp_drained", 32'(obs_valid), 32'd0);

    // Streaming push/pop at count 1 across pointer wrap
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'(16'h0a00 + i), 3'b000, 3'(i), 1'(i), 1'b0, 1'b1, 3'd2);
      if (i > 0) begin
        check_eq("stream_data", 32'(obs_data), 32'(16'h0a00 + i - 1));
        check_eq("stream_ready", 32'(obs_ready), 32'd1);
      end
    end
    idle(1'b1, 3'd0);
    check_eq("stream_last", 32'(obs_data), 32'h0a07);
    idle(1'b1, 3'd0);

    // Setflags gating
    cycle(1'b1, 16'h1111, 3'b100, 3'd4, 1'b1, 1'b0, 1'b1, 3'd0);
    cycle(1'b1, 16'h2222, 3'b110, 3'd5, 1'b1, 1'b1, 1'b1, 3'd0);
    check_eq("gate_hold", 32'(obs_status), 32'b001);
    cycle(1'b0, '0, 3'b000, '0, 1'b0, 1'b0, 1'b1, 3'd3);
    idle(1'b1, 3'd3);
    check_eq("gate_status", 32'(obs_status), 32'b110);
    check_eq("gate_lt", 32'(obs_cond), 32'd0);
    idle(1'b1, 3'd4);
    check_eq("gate_le", 32'(obs_cond), 32'd0);
    idle(1'b1, 3'd2);
    check_eq("gate_ne", 32'(obs_cond), 32'd1);

    // Bypass vs registered flags: status is 110 (Z=0), retire Z=1 with EQ selected
    cycle(1'b1, 16'h3333, 3'b001, 3'd6, 1'b0, 1'b1, 1'b0, 3'd1);
    idle(1'b1, 3'd1);
    check_eq("byp_retire_cycle", 32'(obs_cond), 32'(BYPASS));
    idle(1'b1, 3'd1);
    check_eq("byp_next_cycle", 32'(obs_cond), 32'd1);

    // Reset mid-stream with 2 entries buffered and nonzero status
    cycle(1'b1, 16'h4444, 3'b100, 3'd1, 1'b1, 1'b1, 1'b0, 3'd0);
    cycle(1'b1, 16'h5555, 3'b010, 3'd2, 1'b1, 1'b1, 1'b0, 3'd0);
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(u_if.out_valid), 32'd0);
    check_eq("mid_rst_status", 32'(u_if.status), 32'd0);
    check_eq("mid_rst_data", 32'(u_if.out_data), 32'd0);
    m_q.delete();
    m_status = 3'b000;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(u_if.in_ready), 32'd1);
    idle(1'b1, 3'd0);
    check_eq("mid_rst_no_retire", 32'(obs_status), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0), 3'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Downstream neighbour of the ALU. Captures each ALU result with its 3-bit status vector (bit 0 Z, bit 1 V, bit 2 N), destination register index and control flags.
- Holds captured entries in a small in-order buffer with valid/ready handshakes on both sides.
- Commits the status vector to the architectural status register when an entry retires.
- Evaluates the branch condition from the committed status for the controller.

Parameters:
- DATA_W, 16, width of result data; must match the ALU output width.
- DEPTH, 2, buffer entries; power of two, at least 2.
- REG_IDX_W, 3, width of the destination register index.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream (ALU side) entry valid
- in_ready  output  1  stage can accept an entry this cycle
- in_result  input  DATA_W  ALU result
- in_nvz  input  3  ALU status vector {N,V,Z}
- in_dest  input  REG_IDX_W  destination register index
- in_write  input  1  entry writes the register file
- in_setflags  input  1  entry updates the status register on retire
- out_valid  output  1  head entry valid toward register file
- out_ready  input  1  register file accepts the head entry
- out_data  output  DATA_W  head entry result
- out_dest  output  REG_IDX_W  head entry destination
- out_write  output  1  head entry write enable; qualified by out_valid
- status  output  3  committed {N,V,Z}
- cond_sel  input  3  branch condition select
- cond_true  output  1  selected condition holds

Behaviour:
- Reset, asynchronous and active-high, forces immediately:
  - occupancy 0 and pointers 0
  - out_valid 0, out_data 0, out_dest 0, out_write 0
  - status 3'b000
  - in_ready 1 once reset deasserts
- Reset mid-operation discards all buffered entries. No retirement or status update occurs for them.
- Push: in_valid && in_ready at a clk edge writes the entry at the write pointer. The write pointer wraps modulo DEPTH.
- Pop: out_valid && out_ready at a clk edge retires the head entry. The read pointer wraps modulo DEPTH.
- in_ready = (count != DEPTH). It depends only on registered state, never on out_ready, so a full buffer refuses a push even when a pop happens in the same cycle.
- Latency: minimum 1 cycle. An entry pushed at edge k is visible on out_* after edge k; there is no combinational pass-through when empty.
- Outputs out_data, out_dest and out_write always reflect the head entry. When empty they hold 0 and out_valid is 0.
- Occupancy FSM states and transitions:
  - EMPTY: push goes to PARTIAL (or FULL if DEPTH is reached).
  - PARTIAL: push-only increments; pop-only decrements (to EMPTY at 0); push and pop together hold the count.
  - FULL: pop-only decrements; push is impossible.
- Status commit: on a pop with head in_setflags=1, status takes the head's nvz at that edge. Otherwise status holds its value.
- cond_true is combinational from status:
  - 000 ALWAYS: 1
  - 001 EQ: Z
  - 010 NE: ~Z
  - 011 LT: N^V
  - 100 LE: (N^V)|Z
  - 101 to 111: 0
- Data fields are stored unmodified. The stage performs no arithmetic.

Optional Feature:
- Macro: ALU_WB_FLAG_BYPASS_EN.
- Defined: when a pop with setflags=1 occurs this cycle, cond_true is evaluated on the retiring head's nvz instead of status. The bypass path is combinational from head, out_valid and out_ready. The registered status value is unchanged.
- Undefined: cond_true uses only registered status. A condition sees new flags one cycle after retire.

Decomposition:
- Shared package riscm_pkg holds:
  - nvz bit index constants: NVZ_Z=0, NVZ_V=1, NVZ_N=2
  - cond_sel encodings COND_ALWAYS/EQ/NE/LT/LE
  - default DATA_W and REG_IDX_W
  - the FSM state typedef {EMPTY, PARTIAL, FULL}
- One sub-module, cond_eval: purely combinational mapping of (nvz, cond_sel) to cond_true. It is instantiated once, with its nvz input muxed when bypass is enabled.

Test Plan:
- Reset behaviour: assert reset mid-stream with 2 entries buffered -> out_valid=0, status=000, in_ready=1 after release; no retire observed.
- Single pass: push result=16'h0000, nvz=001, setflags=1, out_ready=1 -> out_data=0 one cycle later; status=001 after pop; cond_sel=EQ gives cond_true=1.
- Backpressure and ordering: out_ready=0, push 16'h1234 then 16'h5678 -> in_ready=0 after 2 pushes; a third in_valid is not accepted. Release out_ready -> outputs 1234 then 5678 in order.
- Simultaneous push/pop at count 1 with out_ready=1 and continuous in_valid over 8 entries -> count stays 1 and all 8 results appear in order, covering pointer wrap.
- Setflags gating: retire nvz=100 with setflags=0 -> status unchanged. Retire nvz=110 with setflags=1 -> status=110; LT gives 0, LE gives 0; NE gives 1.
- Bypass on vs off: retire nvz=001 (setflags=1) with cond_sel=EQ -> with ALU_WB_FLAG_BYPASS_EN defined, cond_true=1 in the retire cycle; without it, cond_true=1 only from the following cycle.
